// File: rtl/scan_pkg.sv
`default_nettype none
// ============================================================================
// scan_pkg : shared sizing constants and scan control-bundle bit ordering
// Revision : 1.0
// ============================================================================
package scan_pkg;

    localparam int DW_DEF = 8;
    localparam int AW_DEF = 4;
    localparam int DEPTH  = 2 ** AW_DEF;

    // Control bundle order shared with the scan FSM: {clr, we, up3, up2, up}
    localparam int CTL_W   = 5;
    localparam int CTL_UP  = 0;
    localparam int CTL_UP2 = 1;
    localparam int CTL_UP3 = 2;
    localparam int CTL_WE  = 3;
    localparam int CTL_CLR = 4;

    function automatic logic [CTL_W-1:0] pack_ctl(
        input logic clr_v,
        input logic we_v,
        input logic up3_v,
        input logic up2_v,
        input logic up_v
    );
        logic [CTL_W-1:0] ctl;
        ctl          = '0;
        ctl[CTL_CLR] = clr_v;
        ctl[CTL_WE]  = we_v;
        ctl[CTL_UP3] = up3_v;
        ctl[CTL_UP2] = up2_v;
        ctl[CTL_UP]  = up_v;
        return ctl;
    endfunction

endpackage
`default_nettype wire

// File: rtl/scan_ram.sv
`default_nettype none
// ============================================================================
// scan_ram : 2**AW x DW register array, sync write, async read, reset to zero
// Revision : 1.0
// ============================================================================
module scan_ram
    import scan_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    localparam int N_WORDS = 2 ** AW;

    logic [DW-1:0] mem_q [N_WORDS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule
`default_nettype wire

// File: rtl/scan_datapath.sv
`default_nettype none
// ============================================================================
// scan_datapath : threshold scan/compaction datapath driven by the scan FSM
// Revision      : 1.0
// ============================================================================
module scan_datapath
    import scan_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          up,
    input  logic          up2,
    input  logic          up3,
    input  logic          we,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    input  logic [DW-1:0] thresh,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic [AW:0]   hit_cnt,
    output logic          GT,
    output logic          RCO
);

    localparam logic [AW:0]   HIT_MAX  = {1'b1, {AW{1'b0}}};
    localparam logic [AW-1:0] ADDR_TOP = {AW{1'b1}};

    logic [CTL_W-1:0] w_ctl;
    logic [DW-1:0]    w_src_rdata;
    logic             w_dst_we;

    logic [AW-1:0] src_addr_q, src_addr_d;
    logic [AW-1:0] dst_addr_q, dst_addr_d;
    logic [AW:0]   hit_cnt_q,  hit_cnt_d;

    assign w_ctl    = pack_ctl(clr, we, up3, up2, up);
    // clr masks the destination write so memory contents survive a clear
    assign w_dst_we = w_ctl[CTL_WE] & ~w_ctl[CTL_CLR];

    scan_ram #(
        .DW (DW),
        .AW (AW)
    ) u_src_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (ld_en),
        .waddr (ld_addr),
        .wdata (ld_data),
        .raddr (src_addr_q),
        .rdata (w_src_rdata)
    );

    scan_ram #(
        .DW (DW),
        .AW (AW)
    ) u_dst_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (w_dst_we),
        .waddr (dst_addr_q),
        .wdata (w_src_rdata),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    always_comb begin
        src_addr_d = src_addr_q;
        dst_addr_d = dst_addr_q;
        hit_cnt_d  = hit_cnt_q;
        if (w_ctl[CTL_CLR]) begin
            src_addr_d = '0;
            dst_addr_d = '0;
            hit_cnt_d  = '0;
        end else begin
            if (w_ctl[CTL_UP]) begin
                src_addr_d = src_addr_q + 1'b1;
            end
            if (w_ctl[CTL_UP2]) begin
                dst_addr_d = dst_addr_q + 1'b1;
            end
            // up3 alone is the FSM's idle level; only a real copy counts
            if (w_ctl[CTL_WE] && w_ctl[CTL_UP3] && (hit_cnt_q != HIT_MAX)) begin
                hit_cnt_d = hit_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_addr_q <= '0;
            dst_addr_q <= '0;
            hit_cnt_q  <= '0;
        end else begin
            src_addr_q <= src_addr_d;
            dst_addr_q <= dst_addr_d;
            hit_cnt_q  <= hit_cnt_d;
        end
    end

    assign hit_cnt = hit_cnt_q;
    assign GT      = (w_src_rdata > thresh);
    assign RCO     = (src_addr_q == ADDR_TOP);

endmodule
`default_nettype wire
